vga_capture: RTL and testbench

- Receive side of the 640x480@60 VGA link driven by our timing generator; used for loopback, self-test and capture from an external source.
- Samples hs/vs and 5-6-5 RGB on the 25 MHz pixel clock, recovers the pixel position, measures line and frame length, and reports lock.
- Emits a registered pixel stream (de, x, y, rgb) for a framebuffer writer or checker.

---
 rtl/vga_capture.sv | 116 +++++++++++
 tb/tb_vga_capture.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/vga_capture.sv
// vga_capture: VGA receive side; recovers pixel position, line/frame length and lock,
// and emits a registered pixel stream aligned with the sampled RGB.
module vga_capture #(
   parameter int H_SYNC     = 96,
   parameter int H_BACK     = 48,
   parameter int H_VISIBLE  = 640,
   parameter int V_SYNC     = 2,
   parameter int V_BACK     = 33,
   parameter int V_VISIBLE  = 480,
   parameter int LOCK_LINES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        hs,
   input  logic        vs,
   input  logic [4:0]  red_in,
   input  logic [5:0]  green_in,
   input  logic [4:0]  blue_in,
   output logic        de,
   output logic [9:0]  x,
   output logic [9:0]  y,
   output logic [4:0]  red,
   output logic [5:0]  green,
   output logic [4:0]  blue,
   output logic [10:0] line_len,
   output logic [10:0] frame_lines,
   output logic        locked,
   output logic        frame_start
);
   localparam logic [10:0] H0  = 11'(H_SYNC + H_BACK);
   localparam logic [10:0] H1  = 11'(H_SYNC + H_BACK + H_VISIBLE);
   localparam logic [10:0] V0  = 11'(V_SYNC + V_BACK);
   localparam logic [10:0] V1  = 11'(V_SYNC + V_BACK + V_VISIBLE);
   localparam logic [10:0] MAX = 11'h7ff;
   logic [2:0]        hs_sync_q, hs_sync_d, vs_sync_q, vs_sync_d;
   logic [2:0][15:0]  pipe_q, pipe_d;
   logic [10:0]       h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d, len;
   logic [10:0]       line_len_q, line_len_d, frame_lines_q, frame_lines_d;
   logic [3:0]        stable_q, stable_d;
   logic              frame_ok_q, frame_ok_d, locked_q, locked_d;
   logic              frame_start_q, frame_start_d, de_q, de_d;
   logic [9:0]        x_q, x_d, y_q, y_d;
   logic [15:0]       rgb_q, rgb_d;
   logic              hs_rise, vs_rise, lost;

   always_comb begin
      hs_sync_d = {hs_sync_q[1:0], hs};
      vs_sync_d = {vs_sync_q[1:0], vs};
      pipe_d = {pipe_q[1:0], {red_in, green_in, blue_in}};
      hs_rise = hs_sync_q[1] & ~hs_sync_q[2];
      vs_rise = vs_sync_q[1] & ~vs_sync_q[2];
      // a saturated line counter means hs has been lost
      lost = h_cnt_q == MAX;
      len = h_cnt_q + 11'd1;
      h_cnt_d = hs_rise ? '0 : (lost ? h_cnt_q : len);
      line_len_d = hs_rise ? len : line_len_q;
      v_cnt_d = vs_rise ? '0 : ((hs_rise && v_cnt_q != MAX) ? v_cnt_q + 11'd1 : v_cnt_q);
      frame_lines_d = vs_rise ? v_cnt_q : frame_lines_q;
      frame_start_d = vs_rise;
      stable_d = (lost || (hs_rise && len != line_len_q)) ? '0 :
                 ((hs_rise && stable_q != 4'hf) ? stable_q + 4'd1 : stable_q);
      frame_ok_d = lost ? 1'b0 : (vs_rise ? (v_cnt_q == frame_lines_q && v_cnt_q != '0) : frame_ok_q);
      locked_d = stable_d >= 4'(LOCK_LINES) && frame_ok_d;
      de_d = locked_q && h_cnt_q >= H0 && h_cnt_q < H1 && v_cnt_q >= V0 && v_cnt_q < V1;
      x_d = de_d ? 10'(h_cnt_q - H0) : '0;
      y_d = de_d ? 10'(v_cnt_q - V0) : '0;
      rgb_d = de_d ? pipe_q[2] : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hs_sync_q     <= '0;
         vs_sync_q     <= '0;
         pipe_q        <= '0;
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         line_len_q    <= '0;
         frame_lines_q <= '0;
         stable_q      <= '0;
         frame_ok_q    <= 1'b0;
         locked_q      <= 1'b0;
         frame_start_q <= 1'b0;
         de_q          <= 1'b0;
         x_q           <= '0;
         y_q           <= '0;
         rgb_q         <= '0;
      end else begin
         hs_sync_q     <= hs_sync_d;
         vs_sync_q     <= vs_sync_d;
         pipe_q        <= pipe_d;
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         line_len_q    <= line_len_d;
         frame_lines_q <= frame_lines_d;
         stable_q      <= stable_d;
         frame_ok_q    <= frame_ok_d;
         locked_q      <= locked_d;
         frame_start_q <= frame_start_d;
         de_q          <= de_d;
         x_q           <= x_d;
         y_q           <= y_d;
         rgb_q         <= rgb_d;
      end
   end

   assign de          = de_q;
   assign x           = x_q;
   assign y           = y_q;
   assign red         = rgb_q[15:11];
   assign green       = rgb_q[10:5];
   assign blue        = rgb_q[4:0];
   assign line_len    = line_len_q;
   assign frame_lines = frame_lines_q;
   assign locked      = locked_q;
   assign frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: drives a scaled-down VGA stream (20 clocks x 12 lines) into vga_capture
// and checks every cycle against a timestamp-based model of the receiver.
module tb_vga_capture;
   localparam int HS = 4, HB = 3, HV = 10, HF = 3, LT = HV + HF + HS + HB;
   localparam int VS = 2, VB = 2, VV = 5, VF = 3, FL = VV + VF + VS + VB;
   localparam int LOCK = 4, H0 = HS + HB, V0 = VS + VB;
   localparam int HS_ST = HV + HF, VS_ST = VV + VF;

   logic clk = 1'b0, rst = 1'b1, hs = 1'b0, vs = 1'b0;
   logic [4:0] red_in = '0, blue_in = '0;
   logic [5:0] green_in = '0;
   logic de, locked, frame_start;
   logic [9:0] x, y;
   logic [4:0] red, blue;
   logic [5:0] green;
   logic [10:0] line_len, frame_lines;

   vga_capture #(.H_SYNC(HS), .H_BACK(HB), .H_VISIBLE(HV), .V_SYNC(VS), .V_BACK(VB),
                 .V_VISIBLE(VV), .LOCK_LINES(LOCK)) dut (
      .clk(clk), .rst(rst), .hs(hs), .vs(vs), .red_in(red_in), .green_in(green_in),
      .blue_in(blue_in), .de(de), .x(x), .y(y), .red(red), .green(green), .blue(blue),
      .line_len(line_len), .frame_lines(frame_lines), .locked(locked), .frame_start(frame_start));

   always #20 clk = ~clk;

   int vecs = 0, errs = 0;
   int de_seen = 0, first_x = -1, first_y = -1;

   // Model state: times are edge counts since reset release.
   int e, t_eff, nl, ll, fl, stable;
   bit fok, lk, hev1, hev2, vev1, vev2, hs_prev, vs_prev;
   logic [15:0] p1, p2, p3;
   int h, ex_x, ex_y, len;
   bit ex_de, ex_fs;
   logic [15:0] ex_rgb;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   initial forever begin
      @(posedge clk);
      if (rst) begin
         e = 0; t_eff = 0; nl = 0; ll = 0; fl = 0; stable = 0; fok = 0; lk = 0;
         {hev1, hev2, vev1, vev2, hs_prev, vs_prev} = '0;
         p1 = '0; p2 = '0; p3 = '0;
         ex_de = 0; ex_x = 0; ex_y = 0; ex_rgb = '0; ex_fs = 0;
      end else begin
         e++;
         h = (e - 1 - t_eff > 2047) ? 2047 : e - 1 - t_eff;
         ex_de = lk && h >= H0 && h < H0 + HV && nl >= V0 && nl < V0 + VV;
         ex_x = ex_de ? h - H0 : 0;
         ex_y = ex_de ? nl - V0 : 0;
         ex_rgb = ex_de ? p3 : '0;
         ex_fs = vev2;
         if (hev2) begin
            len = (h + 1) % 2048;
            stable = (len == ll) ? ((stable == 15) ? 15 : stable + 1) : 0;
            ll = len;
            t_eff = e;
            if (!vev2 && nl < 2047) nl++;
         end
         if (vev2) begin
            fok = (nl == fl) && (nl != 0);
            fl = nl;
            nl = 0;
         end
         if (h == 2047) begin
            stable = 0;
            fok = 0;
         end
         lk = stable >= LOCK && fok;
         hev2 = hev1; hev1 = hs & ~hs_prev; hs_prev = hs;
         vev2 = vev1; vev1 = vs & ~vs_prev; vs_prev = vs;
         p3 = p2; p2 = p1; p1 = {red_in, green_in, blue_in};
      end
      #1;
      vecs++;
      if ({de, x, y, red, green, blue, line_len, frame_lines, locked, frame_start} !==
          {ex_de, 10'(ex_x), 10'(ex_y), ex_rgb, 11'(rst ? 0 : ll), 11'(rst ? 0 : fl), lk, ex_fs}) begin
         errs++;
         $display("FAIL outputs @%0t: got de=%0d x=%0d y=%0d rgb=%h len=%0d fl=%0d lk=%0d fs=%0d, expected de=%0d x=%0d y=%0d rgb=%h len=%0d fl=%0d lk=%0d fs=%0d",
                  $time, de, x, y, {red, green, blue}, line_len, frame_lines, locked, frame_start,
                  ex_de, ex_x, ex_y, ex_rgb, ll, fl, lk, ex_fs);
      end
      if (de === 1'b1) begin
         if (de_seen == 0) begin
            first_x = int'(x);
            first_y = int'(y);
         end
         de_seen++;
      end
   end

   task automatic pix(input logic h_i, input logic v_i, input logic [15:0] c);
      @(negedge clk);
      hs = h_i;
      vs = v_i;
      {red_in, green_in, blue_in} = c;
   endtask

   task automatic line(input int ln, input int n, input bit al);
      logic [9:0] xx, yy;
      bit vis, vb;
      for (int c = 0; c < n; c++) begin
         xx = 10'(c);
         yy = 10'(ln);
         vis = c < HV && ln < VV;
         vb = al ? ((ln == VS_ST && c >= HS_ST) || ln == VS_ST + 1 || (ln == VS_ST + 2 && c < HS_ST))
                 : (ln == VS_ST || ln == VS_ST + 1);
         pix(c >= HS_ST && c < HS_ST + HS, vb,
             vis ? {xx[4:0], yy[5:0], xx[9:5]} : 16'($urandom));
      end
   endtask

   task automatic frame(input int first, input bit al, input int bad_ln, input int bad_len);
      for (int ln = first; ln < FL; ln++) line(ln, ln == bad_ln ? bad_len : LT, al);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_locked", 32'(locked), 0);
      chk("reset_line_len", 32'(line_len), 0);
      rst = 1'b0;
      repeat (5) frame(0, 0, -1, 0);
      chk("line_len", 32'(line_len), LT);
      chk("frame_lines", 32'(frame_lines), FL);
      chk("locked", 32'(locked), 1);
      de_seen = 0;
      frame(0, 0, -1, 0);
      chk("de_per_frame", 32'(de_seen), HV * VV);
      chk("first_x", 32'(first_x), 0);
      chk("first_y", 32'(first_y), 0);
      frame(0, 0, FL - 1, LT + 1);
      line(0, LT, 0);
      chk("long_line_len", 32'(line_len), LT + 1);
      chk("long_line_unlock", 32'(locked), 0);
      frame(1, 0, -1, 0);
      repeat (2) frame(0, 0, -1, 0);
      chk("relock_line", 32'(locked), 1);
      repeat (2100) pix(1'b0, 1'b0, 16'($urandom));
      chk("hs_lost_unlock", 32'(locked), 0);
      repeat (5) frame(0, 0, -1, 0);
      chk("relock_hs", 32'(locked), 1);
      repeat (4) frame(0, 1, -1, 0);
      chk("coincident_frame_lines", 32'(frame_lines), FL - 1);
      chk("coincident_locked", 32'(locked), 1);
      repeat (3) frame(0, 0, -1, 0);
      for (int i = 0; i < 4; i++) frame(0, 0, int'($urandom_range(FL - 1, 0)), int'($urandom_range(LT + 2, LT - 2)));
      repeat (3) frame(0, 0, -1, 0);
      chk("locked_before_rst", 32'(locked), 1);
      line(0, LT, 0); line(1, LT, 0); line(2, LT, 0);
      repeat (5) pix(1'b0, 1'b0, 16'($urandom));
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("async_rst_locked", 32'(locked), 0);
      chk("async_rst_line_len", 32'(line_len), 0);
      chk("async_rst_frame_lines", 32'(frame_lines), 0);
      repeat (3) pix(1'b0, 1'b0, 16'($urandom));
      rst = 1'b0;
      line(3, LT - 9, 0);
      frame(4, 0, -1, 0);
      frame(0, 0, -1, 0);
      chk("post_rst_unlocked", 32'(locked), 0);
      repeat (3) frame(0, 0, -1, 0);
      chk("post_rst_relock", 32'(locked), 1);
      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
